// File: rtl/cache_pkg.sv
// Shared cache-side types and defaults used by the write-back drain path.
package cache_pkg;

   localparam int ADDR_WIDTH          = 32;
   localparam int DATA_WIDTH          = 128;
   localparam int DEF_MEM_DATA_WIDTH  = 32;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_SEND,
      WB_WAIT_ACK
   } wb_wr_state_t;

endpackage

// File: rtl/line_serializer.sv
// Parallel-load line register that shifts out one memory-bus slice per beat,
// LSB slice first, with a beat counter and a final-beat flag.
module line_serializer #(
   parameter int WIDTH     = 128,
   parameter int SLICE     = 32,
   parameter int BEAT_BITS = 2
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 load_i,
   input  logic [WIDTH-1:0]     data_i,
   input  logic                 shift_i,
   output logic [SLICE-1:0]     slice_o,
   output logic [BEAT_BITS-1:0] beat_cnt_o,
   output logic                 last_o
);

   localparam int BEATS = WIDTH / SLICE;
   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

   logic [WIDTH-1:0]     shift_q;
   logic [BEAT_BITS-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (load_i) begin
         shift_q <= data_i;
         cnt_q   <= '0;
      end else if (shift_i) begin
         shift_q <= shift_q >> SLICE;
         // wrap to zero on the final beat so the next line starts clean
         cnt_q   <= last_o ? '0 : cnt_q + BEAT_BITS'(1);
      end
   end

   assign slice_o    = shift_q[SLICE-1:0];
   assign beat_cnt_o = cnt_q;
   assign last_o     = (cnt_q == LAST_BEAT);

endmodule

// File: rtl/wb_mem_writer.sv
// Drains one dirty line at a time from the write-back buffer and writes it to
// memory as a burst; the in-flight line address is exposed for hazard checks.
module wb_mem_writer
   import cache_pkg::*;
#(
   parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   // buffer side: valid/ready handshake, a line transfers on a cycle where
   // valid_i & ready_o are both high; ready_o never depends on valid_i
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic [DATA_WIDTH-1:0]     data_i,
   // memory side: a beat transfers on a cycle where mem_req_o & mem_gnt_i
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
   output logic                      mem_last_o,
   input  logic                      mem_ack_i,
   output logic                      pend_valid_o,
   output logic [ADDR_WIDTH-1:0]     pend_addr_o,
   output logic                      busy_o
);

   localparam int BEATS      = DATA_WIDTH / MEM_DATA_WIDTH;
   localparam int OFF_BITS   = $clog2(DATA_WIDTH / 8);
   localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BEAT_BYTES = MEM_DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
      ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

   wb_wr_state_t              state_q, state_d;
   logic [ADDR_WIDTH-1:0]     line_addr_q;
   logic                      accept;
   logic                      load;
   logic                      shift;
   logic                      in_send;
   logic                      ser_last;
   logic [BEAT_BITS-1:0]      beat_cnt;
   logic [MEM_DATA_WIDTH-1:0] beat_data;

   assign ready_o = (state_q == WB_IDLE);
   assign accept  = valid_i & ready_o;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= WB_IDLE;
         line_addr_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            line_addr_q <= addr_i & ~OFF_MASK;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (accept) begin
               load    = 1'b1;
               state_d = WB_SEND;
            end
         end
         WB_SEND: begin
            if (mem_gnt_i) begin
               shift = 1'b1;
               if (ser_last) begin
                  state_d = WB_WAIT_ACK;
               end
            end
         end
         WB_WAIT_ACK: begin
            if (mem_ack_i) begin
               state_d = WB_IDLE;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   line_serializer #(
      .WIDTH     (DATA_WIDTH),
      .SLICE     (MEM_DATA_WIDTH),
      .BEAT_BITS (BEAT_BITS)
   ) u_ser (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .load_i     (load),
      .data_i     (data_i),
      .shift_i    (shift),
      .slice_o    (beat_data),
      .beat_cnt_o (beat_cnt),
      .last_o     (ser_last)
   );

   // beat outputs are forced to zero outside SEND so idle/reset reads are clean
   assign in_send     = (state_q == WB_SEND);
   assign mem_req_o   = in_send;
   assign mem_addr_o  = in_send ?
                        line_addr_q + ADDR_WIDTH'(beat_cnt) * ADDR_WIDTH'(BEAT_BYTES) : '0;
   assign mem_wdata_o = in_send ? beat_data : '0;
   assign mem_last_o  = in_send & ser_last;

   assign pend_valid_o = (state_q != WB_IDLE);
   assign pend_addr_o  = pend_valid_o ? line_addr_q : '0;
   assign busy_o       = pend_valid_o;

endmodule

// File: tb/tb_wb_mem_writer.sv
// Randomized scoreboard bench for wb_mem_writer: a buffer model feeds lines,
// expected beats are queued at each handshake and checked on every grant.
module tb_wb_mem_writer;
   import cache_pkg::*;

   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int MW = DEF_MEM_DATA_WIDTH;
   localparam int NB = DW / MW;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [AW-1:0] addr_i = '0;
   logic [DW-1:0] data_i = '0;
   logic          mem_req_o;
   logic          mem_gnt_i = 1'b0;
   logic [AW-1:0] mem_addr_o;
   logic [MW-1:0] mem_wdata_o;
   logic          mem_last_o;
   logic          mem_ack_i = 1'b0;
   logic          pend_valid_o;
   logic [AW-1:0] pend_addr_o;
   logic          busy_o;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } line_t;

   line_t         buf_q[$];
   logic [AW+MW:0] exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            n_hs = 0;
   bit            in_flight = 0;
   logic [AW-1:0] cur_addr = '0;
   int            ack_timer = 0;
   int            ack_delay = 1;
   bit            ack_rand = 0;
   bit            spur_pending = 0;
   bit            gnt_low_all = 0;
   bit            gnt_rand = 0;
   int            hold_beat = -1;
   int            hold_left = 0;
   bit            prev_stall = 0;
   logic [AW+MW:0] prev_beat = '0;

   wb_mem_writer #(.MEM_DATA_WIDTH(MW)) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .addr_i       (addr_i),
      .data_i       (data_i),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_last_o   (mem_last_o),
      .mem_ack_i    (mem_ack_i),
      .pend_valid_o (pend_valid_o),
      .pend_addr_o  (pend_addr_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push_line(input logic [AW-1:0] a, input logic [DW-1:0] d);
      line_t l;
      l.addr = a;
      l.data = d;
      buf_q.push_back(l);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", ready_o, 1'b1);
      check("rst_req", mem_req_o, 1'b0);
      check("rst_last", mem_last_o, 1'b0);
      check("rst_pend_valid", pend_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_mem_addr", mem_addr_o, '0);
      check("rst_wdata", mem_wdata_o, '0);
      check("rst_pend_addr", pend_addr_o, '0);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_i);
         #2;
         if (buf_q.size() == 0 && !in_flight) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL timeout_%s: got busy expected idle", name);
   endtask

   // buffer, grant and ack drivers; inputs change 1ns after the active edge
   always @(posedge clk_i) begin
      #1;
      valid_i = (buf_q.size() > 0);
      if (buf_q.size() > 0) begin
         addr_i = buf_q[0].addr;
         data_i = buf_q[0].data;
      end
      if (gnt_low_all) begin
         mem_gnt_i = 1'b0;
      end else if (hold_left > 0 && in_flight && exp_q.size() > 0 &&
                   (NB - exp_q.size()) == hold_beat) begin
         mem_gnt_i = 1'b0;
         hold_left--;
      end else begin
         mem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      mem_ack_i = 1'b0;
      if (spur_pending && in_flight && exp_q.size() > 0) begin
         mem_ack_i    = 1'b1;
         spur_pending = 0;
      end else if (ack_timer == 1) begin
         mem_ack_i = 1'b1;
      end
      if (ack_timer > 0) ack_timer--;
   end

   // monitor + reference model, evaluated at the falling edge
   always @(negedge clk_i) begin
      if (rstn_i) begin
         bit waiting;
         waiting = in_flight && exp_q.size() == 0;
         check("ready", ready_o, !in_flight);
         check("busy", busy_o, in_flight);
         check("pend_valid", pend_valid_o, in_flight);
         check("pend_addr", pend_addr_o, in_flight ? cur_addr : '0);
         check("req", mem_req_o, in_flight && exp_q.size() > 0);
         if (prev_stall)
            check("hold_beat", {mem_addr_o, mem_wdata_o, mem_last_o}, prev_beat);
         if (mem_req_o && mem_gnt_i) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL beat_unexpected: got addr %0h expected none", mem_addr_o);
            end else begin
               check("beat", {mem_addr_o, mem_wdata_o, mem_last_o}, exp_q.pop_front());
               if (exp_q.size() == 0)
                  ack_timer = ack_rand ? int'($urandom_range(1, 6)) : ack_delay;
            end
         end
         prev_stall = mem_req_o && !mem_gnt_i;
         prev_beat  = {mem_addr_o, mem_wdata_o, mem_last_o};
         if (waiting && mem_ack_i) in_flight = 0;
         if (valid_i && ready_o && buf_q.size() > 0) begin
            line_t l;
            l = buf_q.pop_front();
            n_hs++;
            cur_addr  = l.addr - (l.addr % (DW / 8));
            in_flight = 1;
            for (int i = 0; i < NB; i++)
               exp_q.push_back({AW'(cur_addr + i * (MW / 8)), l.data[i*MW +: MW], (i == NB - 1)});
         end
      end
   end

   initial begin
      logic [DW-1:0] d1;
      bit hit;
      d1 = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;

      repeat (3) @(posedge clk_i);
      #1;
      check_reset_outputs();
      @(negedge clk_i);
      #2 rstn_i = 1'b1;

      // basic burst, immediate grant, ack one cycle after last beat
      push_line(32'h0000_1234, d1);
      wait_idle("basic");

      // grant withheld for 3 cycles on beat 1
      hold_beat = 1;
      hold_left = 3;
      push_line(32'h0000_1234, d1);
      wait_idle("backpressure");
      hold_beat = -1;

      // late ack with a spurious ack during SEND
      ack_delay    = 10;
      spur_pending = 1;
      push_line(32'h0000_1234, d1);
      wait_idle("late_ack");

      // two queued lines with random grant
      ack_delay = 2;
      gnt_rand  = 1;
      n_hs      = 0;
      push_line(32'h0000_0100, {$urandom, $urandom, $urandom, $urandom});
      push_line(32'h0000_0200, {$urandom, $urandom, $urandom, $urandom});
      wait_idle("b2b");
      check("b2b_handshakes", n_hs, 2);
      gnt_rand = 0;

      // reset after beat 1 is granted
      push_line(32'h0000_4568, {$urandom, $urandom, $urandom, $urandom});
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk_i);
         #2;
         if (in_flight && exp_q.size() == NB - 2) hit = 1;
      end
      check("reset_reach_beat2", hit, 1'b1);
      rstn_i = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      in_flight  = 0;
      ack_timer  = 0;
      prev_stall = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #2 rstn_i = 1'b1;
      push_line(32'h0000_8000, {$urandom, $urandom, $urandom, $urandom});
      wait_idle("after_reset");

      // grant held low: exactly one pop while a second line waits
      gnt_low_all = 1;
      push_line(32'h0000_0300, {$urandom, $urandom, $urandom, $urandom});
      push_line(32'h0000_0400, {$urandom, $urandom, $urandom, $urandom});
      repeat (30) @(negedge clk_i);
      #2;
      check("stall_pops", buf_q.size(), 1);
      check("stall_ready", ready_o, 1'b0);
      gnt_low_all = 0;
      wait_idle("stall_drain");

      // random traffic
      gnt_rand = 1;
      ack_rand = 1;
      for (int i = 0; i < 20; i++)
         push_line($urandom, {$urandom, $urandom, $urandom, $urandom});
      wait_idle("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
